pilha_ctrl: RTL and testbench

Instruction sequencer that drives the stack/register/ALU datapath from the initiator side. It accepts one instruction at a time over a valid/ready handshake and generates the `push`, `pop`, `load`, `opcode` and `din` controls. It monitors `empty`, `full`, `s_ula` and `carryout`, and writes ALU results back onto the stack. It sits between the instruction source (bench, ROM or future fetch unit) and the datapath integration block.

---
 rtl/pilha_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pilha_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pilha_ctrl.sv
// Instruction sequencer for the stack/register/ALU datapath: accepts one instruction
// per valid/ready handshake and steps the push/pop/load/opcode controls.
module pilha_ctrl #(
  parameter logic [4:0] LDA_CODE = 5'b11110,
  parameter logic [4:0] LDB_CODE = 5'b11111,
  parameter logic [4:0] NOP_CODE = 5'b00000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [1:0] instr_op,
  input  logic [7:0] instr_imm,
  input  logic [4:0] instr_alu,
  output logic       push,
  output logic       pop,
  output logic       load,
  output logic [4:0] opcode,
  output logic [7:0] din,
  input  logic       empty,
  input  logic       full,
  input  logic [7:0] s_ula,
  input  logic       carryout,
  output logic [7:0] result,
  output logic       carry_flag,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_code
);

  typedef enum logic [3:0] {
    S_IDLE, S_PUSHI, S_DROP, S_POPA, S_LDA, S_POPB, S_LDB, S_EXEC, S_WB
  } state_t;

  localparam logic [1:0] OP_PUSHI = 2'b01;
  localparam logic [1:0] OP_DROP  = 2'b10;
  localparam logic [1:0] OP_ALU   = 2'b11;
  localparam logic [1:0] ERR_UNF  = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;

  state_t     state_q, state_d;
  logic [4:0] alu_q, alu_d;
  logic [7:0] din_q, din_d;
  logic [7:0] result_q, result_d;
  logic       carry_q, carry_d;
  logic       err_q, err_d;
  logic [1:0] err_code_q, err_code_d;
  logic       push_q, push_d;
  logic       pop_q, pop_d;
  logic       load_q, load_d;
  logic [4:0] opcode_q, opcode_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    alu_d      = alu_q;
    din_d      = din_q;
    result_d   = result_q;
    carry_d    = carry_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    unique case (state_q)
      S_IDLE: begin
        if (instr_valid && ready_q) begin
          alu_d = instr_alu;
          unique case (instr_op)
            OP_PUSHI: begin
              if (full) begin
                err_d      = 1'b1;
                err_code_d = ERR_OVF;
              end else begin
                state_d = S_PUSHI;
                din_d   = instr_imm;
              end
            end
            OP_DROP, OP_ALU: begin
              if (empty) begin
                err_d      = 1'b1;
                err_code_d = ERR_UNF;
              end else begin
                state_d = (instr_op == OP_DROP) ? S_DROP : S_POPA;
              end
            end
            default: ;
          endcase
        end
      end
      S_PUSHI, S_DROP: state_d = S_IDLE;
      S_POPA:          state_d = S_LDA;
      S_LDA: begin
        // Only one operand was present: it now sits in temp1 and is discarded.
        if (empty) begin
          err_d      = 1'b1;
          err_code_d = ERR_UNF;
          state_d    = S_IDLE;
        end else begin
          state_d = S_POPB;
        end
      end
      S_POPB: state_d = S_LDB;
      S_LDB:  state_d = S_EXEC;
      S_EXEC: begin
        result_d = s_ula;
        din_d    = s_ula;
        carry_d  = carryout;
        state_d  = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so they are registered yet line up with it.
    push_d  = (state_d == S_PUSHI) || (state_d == S_WB);
    pop_d   = (state_d == S_DROP) || (state_d == S_POPA) || (state_d == S_POPB);
    load_d  = (state_d == S_LDA) || (state_d == S_LDB);
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);

    unique case (state_d)
      S_LDA:   opcode_d = LDA_CODE;
      S_LDB:   opcode_d = LDB_CODE;
      S_EXEC:  opcode_d = alu_d;
      default: opcode_d = NOP_CODE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      alu_q      <= 5'd0;
      din_q      <= 8'h00;
      result_q   <= 8'h00;
      carry_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      load_q     <= 1'b0;
      opcode_q   <= NOP_CODE;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_q      <= alu_d;
      din_q      <= din_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      push_q     <= push_d;
      pop_q      <= pop_d;
      load_q     <= load_d;
      opcode_q   <= opcode_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign push        = push_q;
  assign pop         = pop_q;
  assign load        = load_q;
  assign opcode      = opcode_q;
  assign din         = din_q;
  assign result      = result_q;
  assign carry_flag  = carry_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_pilha_ctrl.sv
// Bench for pilha_ctrl: behavioural stack/ALU datapath around the DUT, a per-instruction
// reference model that queues expected strobe events, and a monitor that consumes them.
module tb_pilha_ctrl;

  localparam logic [4:0] LDA_CODE = 5'b11110;
  localparam logic [4:0] LDB_CODE = 5'b11111;
  localparam logic [4:0] NOP_CODE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b00010;
  localparam logic [4:0] ALU_AND  = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_PUSHI = 2'b01;
  localparam logic [1:0] OP_DROP  = 2'b10;
  localparam logic [1:0] OP_ALU   = 2'b11;
  localparam int         DEPTH    = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid, instr_ready;
  logic [1:0] instr_op;
  logic [7:0] instr_imm;
  logic [4:0] instr_alu;
  logic       push, pop, load;
  logic [4:0] opcode;
  logic [7:0] din;
  logic       empty, full;
  logic [7:0] s_ula;
  logic       carryout;
  logic [7:0] result;
  logic       carry_flag, busy, err;
  logic [1:0] err_code;

  pilha_ctrl dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_imm(instr_imm), .instr_alu(instr_alu),
    .push(push), .pop(pop), .load(load), .opcode(opcode), .din(din),
    .empty(empty), .full(full), .s_ula(s_ula), .carryout(carryout),
    .result(result), .carry_flag(carry_flag), .busy(busy),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(string name, bit ok, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ALU behaviour: bit 8 is the carry (or the borrow for subtraction).
  function automatic logic [8:0] alu_fn(logic [4:0] sel, logic [7:0] a, logic [7:0] b);
    case (sel)
      ALU_ADD: return {1'b0, a} + {1'b0, b};
      ALU_SUB: return {1'b0, a} - {1'b0, b};
      ALU_AND: return {1'b0, a & b};
      ALU_XOR: return {1'b0, a ^ b};
      default: return 9'd0;
    endcase
  endfunction

  // Datapath model: stack with registered output, temp1/temp2, combinational ALU.
  logic [7:0] stk [DEPTH];
  int         dp_depth;
  logic [7:0] stk_out, temp1, temp2;

  assign empty = (dp_depth == 0);
  assign full  = (dp_depth == DEPTH);
  always_comb {carryout, s_ula} = alu_fn(opcode, temp1, temp2);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_depth <= 0;
      stk_out  <= 8'h00;
      temp1    <= 8'h00;
      temp2    <= 8'h00;
    end else begin
      if (push && dp_depth < DEPTH) begin
        stk[dp_depth] <= din;
        dp_depth      <= dp_depth + 1;
      end else if (pop && dp_depth > 0) begin
        stk_out  <= stk[dp_depth-1];
        dp_depth <= dp_depth - 1;
      end
      if (load && opcode == LDA_CODE) temp1 <= stk_out;
      else if (load && opcode == LDB_CODE) temp2 <= stk_out;
    end
  end

  // Scoreboard.
  typedef enum logic [1:0] {EV_PUSH, EV_POP, EV_LOAD, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    int         cyc;
    logic [7:0] data;
    bit         chk_res;
    logic [7:0] res;
    logic       carry;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] ref_q[$];
  int         exp_ready = -1;

  task automatic expect_ev(ev_kind_e k, int c, logic [7:0] d,
                           bit cr = 1'b0, logic [7:0] r = 8'h00, logic cy = 1'b0);
    ev_t e;
    e.kind = k; e.cyc = c; e.data = d; e.chk_res = cr; e.res = r; e.carry = cy;
    exp_q.push_back(e);
  endtask

  // Reference model: outcome of one instruction accepted at the edge following cycle n.
  task automatic predict(logic [1:0] op, logic [7:0] imm, logic [4:0] sel, int n);
    logic [7:0] a, b;
    logic [8:0] r;
    case (op)
      OP_NOP: exp_ready = n + 1;
      OP_PUSHI: begin
        if (ref_q.size() == DEPTH) begin
          expect_ev(EV_ERR, n + 1, 8'd2);
          exp_ready = n + 1;
        end else begin
          expect_ev(EV_PUSH, n + 1, imm);
          ref_q.push_back(imm);
          exp_ready = n + 2;
        end
      end
      OP_DROP: begin
        if (ref_q.size() == 0) begin
          expect_ev(EV_ERR, n + 1, 8'd1);
          exp_ready = n + 1;
        end else begin
          expect_ev(EV_POP, n + 1, 8'd0);
          void'(ref_q.pop_back());
          exp_ready = n + 2;
        end
      end
      default: begin
        if (ref_q.size() == 0) begin
          expect_ev(EV_ERR, n + 1, 8'd1);
          exp_ready = n + 1;
        end else if (ref_q.size() == 1) begin
          expect_ev(EV_POP, n + 1, 8'd0);
          expect_ev(EV_LOAD, n + 2, {3'b0, LDA_CODE});
          expect_ev(EV_ERR, n + 3, 8'd1);
          void'(ref_q.pop_back());
          exp_ready = n + 3;
        end else begin
          a = ref_q.pop_back();
          b = ref_q.pop_back();
          r = alu_fn(sel, a, b);
          expect_ev(EV_POP, n + 1, 8'd0);
          expect_ev(EV_LOAD, n + 2, {3'b0, LDA_CODE});
          expect_ev(EV_POP, n + 3, 8'd0);
          expect_ev(EV_LOAD, n + 4, {3'b0, LDB_CODE});
          expect_ev(EV_PUSH, n + 6, r[7:0], 1'b1, r[7:0], r[8]);
          ref_q.push_back(r[7:0]);
          exp_ready = n + 7;
        end
      end
    endcase
  endtask

  // Monitor: samples on the falling edge, matches every strobe/err against the queue.
  always @(negedge clk) begin
    int       n;
    ev_kind_e kind;
    ev_t      e;
    if (!rst) begin
      n = int'(push) + int'(pop) + int'(load) + int'(err);
      check("one_strobe", n <= 1, n, 1);
      check("busy_vs_ready", busy == !instr_ready, busy, !instr_ready);
      if (n >= 1) begin
        kind = push ? EV_PUSH : pop ? EV_POP : load ? EV_LOAD : EV_ERR;
        if (exp_q.size() == 0) begin
          check("unexpected_event", 1'b0, kind, 0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", kind == e.kind, kind, e.kind);
          check("event_cycle", cyc == e.cyc, cyc, e.cyc);
          case (kind)
            EV_PUSH: begin
              check("push_din", din == e.data, din, e.data);
              if (e.chk_res) begin
                check("alu_result", result == e.res, result, e.res);
                check("alu_carry", carry_flag == e.carry, carry_flag, e.carry);
              end
            end
            EV_LOAD: check("load_opcode", opcode == e.data[4:0], opcode, e.data[4:0]);
            EV_ERR:  check("err_code", err_code == e.data[1:0], err_code, e.data[1:0]);
            default: ;
          endcase
        end
      end
    end
  end

  // Wait (bounded) at falling edges until instr_ready, checking the predicted latency.
  task automatic wait_ready();
    int k = 0;
    while (!instr_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!instr_ready) check("ready_timeout", 1'b0, 0, 1);
    if (exp_ready >= 0) check("ready_latency", cyc == exp_ready, cyc, exp_ready);
    exp_ready = -1;
  endtask

  // Present an instruction, hold it until accepted, return one falling edge later with
  // instr_valid still high; the caller follows immediately with send() or wait_idle().
  task automatic send(logic [1:0] op, logic [7:0] imm, logic [4:0] sel);
    instr_op    = op;
    instr_imm   = imm;
    instr_alu   = sel;
    instr_valid = 1'b1;
    wait_ready();
    predict(op, imm, sel, cyc);
    @(posedge clk);
    @(negedge clk);
    instr_op  = 2'($urandom);
    instr_imm = 8'($urandom);
    instr_alu = 5'($urandom);
  endtask

  task automatic wait_idle();
    instr_valid = 1'b0;
    wait_ready();
    check("stack_depth", dp_depth == ref_q.size(), dp_depth, ref_q.size());
    for (int i = 0; i < ref_q.size() && i < dp_depth; i++)
      check("stack_entry", stk[i] == ref_q[i], stk[i], ref_q[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] sels [4];
    int         k;
    sels[0] = ALU_ADD; sels[1] = ALU_SUB; sels[2] = ALU_AND; sels[3] = ALU_XOR;
    rst = 1'b1; instr_valid = 1'b0; instr_op = OP_NOP; instr_imm = 8'h00; instr_alu = 5'd0;
    repeat (2) @(negedge clk);

    check("rst_push", push == 1'b0, push, 0);
    check("rst_pop", pop == 1'b0, pop, 0);
    check("rst_load", load == 1'b0, load, 0);
    check("rst_err", err == 1'b0, err, 0);
    check("rst_opcode", opcode == NOP_CODE, opcode, NOP_CODE);
    check("rst_din", din == 8'h00, din, 0);
    check("rst_result", result == 8'h00, result, 0);
    check("rst_carry", carry_flag == 1'b0, carry_flag, 0);
    check("rst_err_code", err_code == 2'b00, err_code, 0);
    check("rst_ready", instr_ready == 1'b1, instr_ready, 1);
    check("rst_busy", busy == 1'b0, busy, 0);
    #1 rst = 1'b0;
    @(negedge clk);

    // ALU on an empty stack, then push-then-add.
    send(OP_ALU, 8'h00, ALU_ADD); wait_idle();
    send(OP_PUSHI, 8'h12, 5'd0); wait_idle();
    send(OP_PUSHI, 8'h34, 5'd0); wait_idle();
    send(OP_ALU, 8'h00, ALU_ADD); wait_idle();
    check("add_result", result == 8'h46, result, 8'h46);
    check("add_carry", carry_flag == 1'b0, carry_flag, 0);
    check("add_top", stk[0] == 8'h46, stk[0], 8'h46);

    // Carry out of the adder.
    send(OP_PUSHI, 8'hF0, 5'd0); send(OP_PUSHI, 8'h20, 5'd0);
    send(OP_ALU, 8'h00, ALU_ADD); wait_idle();
    check("carry_result", result == 8'h10, result, 8'h10);
    check("carry_flag", carry_flag == 1'b1, carry_flag, 1);

    // One operand: pop, LDA, then underflow.
    send(OP_DROP, 8'h00, 5'd0); wait_idle();
    send(OP_ALU, 8'h00, ALU_SUB); wait_idle();
    check("unf_code", err_code == 2'b01, err_code, 2'b01);

    // Overflow on a full stack.
    for (int i = 0; i < DEPTH; i++) send(OP_PUSHI, 8'h50 + 8'(i), 5'd0);
    wait_idle();
    check("full_flag", full == 1'b1, full, 1);
    send(OP_PUSHI, 8'hAA, 5'd0); wait_idle();
    check("ovf_code", err_code == 2'b10, err_code, 2'b10);
    for (int i = 0; i < DEPTH; i++) send(OP_DROP, 8'h00, 5'd0);
    wait_idle();

    // Back-to-back acceptance with instr_valid held high.
    send(OP_PUSHI, 8'h01, 5'd0);
    send(OP_PUSHI, 8'h02, 5'd0);
    send(OP_PUSHI, 8'h03, 5'd0);
    wait_idle();

    // Randomized mix, sometimes back-to-back.
    for (int i = 0; i < 120; i++) begin
      send(2'($urandom_range(0, 3)), 8'($urandom), sels[$urandom_range(0, 3)]);
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();

    // Reset while the ALU sequence sits in LDB.
    while (ref_q.size() > 0) send(OP_DROP, 8'h00, 5'd0);
    send(OP_PUSHI, 8'h11, 5'd0); send(OP_PUSHI, 8'h22, 5'd0);
    send(OP_ALU, 8'h00, ALU_ADD);
    instr_valid = 1'b0;
    k = 0;
    while (!(load && opcode == LDB_CODE) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("reach_ldb", load && opcode == LDB_CODE, {load, opcode}, {1'b1, LDB_CODE});
    #1 rst = 1'b1;
    #1;
    check("mid_rst_load", load == 1'b0, load, 0);
    check("mid_rst_push", push == 1'b0, push, 0);
    check("mid_rst_pop", pop == 1'b0, pop, 0);
    check("mid_rst_opcode", opcode == NOP_CODE, opcode, NOP_CODE);
    check("mid_rst_ready", instr_ready == 1'b1, instr_ready, 1);
    check("mid_rst_busy", busy == 1'b0, busy, 0);
    exp_q.delete();
    ref_q.delete();
    exp_ready = -1;
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    send(OP_PUSHI, 8'h5A, 5'd0); wait_idle();
    send(OP_DROP, 8'h00, 5'd0); wait_idle();

    @(negedge clk);
    check("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
